// File: rtl/code_entry.sv
// code_entry: keypad digit capture for a code lock.
//
// Collects BCD digits from a debounced keypad into an entry buffer, compares
// the completed entry against a stored code, and lets an unlocked lock
// reprogram that code. The first digit entered lands in the most-significant
// nibble of the buffer.
//
// Ports
//   clk              single clock, rising-edge active
//   rst              asynchronous active-high reset
//   key_valid        debounced "key down" level
//   key_digit [3:0]  digit code, meaningful while key_valid is high
//   clear            discard the current entry
//   submit           submit strobe (shared with the control FSM)
//   ready_for_input  digits are accepted only while this is high
//   unlock_led       lock currently open
//   prog_en          program-new-code request
//   full             DIGITS digits captured
//   match            captured entry equals the stored code
//   digit_count[2:0] number of digits captured, 0..DIGITS
//   key_err          one-cycle pulse when a keypress is rejected
//   code_loaded      one-cycle pulse after the stored code is reprogrammed
module code_entry #(
  parameter int                  DIGITS       = 4,
  parameter logic [4*DIGITS-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       clear,
  input  logic       submit,
  input  logic       ready_for_input,
  input  logic       unlock_led,
  input  logic       prog_en,
  output logic       full,
  output logic       match,
  output logic [2:0] digit_count,
  output logic       key_err,
  output logic       code_loaded
);

  localparam int         W        = 4 * DIGITS;
  localparam logic [2:0] DIGITS_C = 3'(DIGITS);

  logic [W-1:0] buf_r;
  logic [W-1:0] stored_r;
  logic [2:0]   count_r;
  logic         key_valid_q_r;
  logic         key_err_r;
  logic         code_loaded_r;

  logic         press_s;
  logic         full_s;
  logic         accept_s;
  logic         reprog_s;
  logic [W-1:0] buf_next_s;

  // Press detection, acceptance decision and the buffer with the new digit inserted.
  always_comb begin
    press_s    = key_valid & ~key_valid_q_r;
    full_s     = (count_r == DIGITS_C);
    accept_s   = press_s & ready_for_input & (key_digit <= 4'd9) & (count_r < DIGITS_C);
    reprog_s   = submit & full_s & prog_en & unlock_led;
    buf_next_s = buf_r;
    // Slot k sits k nibbles below the top, so the first digit is the MS nibble.
    for (int i = 0; i < DIGITS; i++) begin
      if (count_r == 3'(i)) begin
        buf_next_s[(DIGITS-1-i)*4 +: 4] = key_digit;
      end else begin
        buf_next_s[(DIGITS-1-i)*4 +: 4] = buf_r[(DIGITS-1-i)*4 +: 4];
      end
    end
  end

  // Entry buffer, digit counter, stored code and the one-cycle status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r         <= {W{1'b0}};
      stored_r      <= DEFAULT_CODE;
      count_r       <= 3'd0;
      key_valid_q_r <= 1'b1;  // a key held through reset must be released first
      key_err_r     <= 1'b0;
      code_loaded_r <= 1'b0;
    end else begin
      key_valid_q_r <= key_valid;
      key_err_r     <= 1'b0;
      code_loaded_r <= 1'b0;
      if (clear || submit) begin
        // clear/submit take priority; a coincident press is silently dropped.
        buf_r   <= {W{1'b0}};
        count_r <= 3'd0;
        if (reprog_s) begin
          stored_r      <= buf_r;
          code_loaded_r <= 1'b1;
        end
      end else if (press_s) begin
        if (accept_s) begin
          buf_r   <= buf_next_s;
          count_r <= count_r + 3'd1;
        end else begin
          key_err_r <= 1'b1;
        end
      end
    end
  end

  // full/match come straight from registers so the control FSM sees them with no extra delay.
  always_comb begin
    full        = full_s;
    match       = full_s & (buf_r == stored_r);
    digit_count = count_r;
    key_err     = key_err_r;
    code_loaded = code_loaded_r;
  end

endmodule

// File: tb/tb_code_entry.sv
// Self-checking bench for code_entry: directed scenarios plus a randomized
// run compared against a queue-based model of the entry and stored code.
module tb_code_entry;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       clear;
  logic       submit;
  logic       ready_for_input;
  logic       unlock_led;
  logic       prog_en;
  logic       full;
  logic       match;
  logic [2:0] digit_count;
  logic       key_err;
  logic       code_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the entry as a list of digits, the stored code as a number.
  int q[$];
  int m_stored;
  bit m_prev_kv;
  bit m_err;
  bit m_loaded;

  code_entry dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_digit(key_digit),
    .clear(clear), .submit(submit), .ready_for_input(ready_for_input),
    .unlock_led(unlock_led), .prog_en(prog_en), .full(full), .match(match),
    .digit_count(digit_count), .key_err(key_err), .code_loaded(code_loaded)
  );

  always #5 clk = ~clk;

  function automatic int q_value();
    int v = 0;
    foreach (q[i]) v = v * 16 + q[i];
    return v;
  endfunction

  task automatic model_reset();
    q.delete();
    m_stored  = 'h1234;
    m_prev_kv = 1'b1;
    m_err     = 1'b0;
    m_loaded  = 1'b0;
  endtask

  // Apply inputs for one clock (called at a falling edge, returns at the next one).
  task automatic step(input logic kv, input logic [3:0] d, input logic clr, input logic sub);
    bit press;
    key_valid = kv; key_digit = d; clear = clr; submit = sub;
    @(posedge clk);
    press    = kv && !m_prev_kv;
    m_err    = 1'b0;
    m_loaded = 1'b0;
    if (clr || sub) begin
      if (sub && q.size() == 4 && prog_en && unlock_led) begin
        m_stored = q_value();
        m_loaded = 1'b1;
      end
      q.delete();
    end else if (press) begin
      if (ready_for_input && d <= 9 && q.size() < 4) q.push_back(int'(d));
      else m_err = 1'b1;
    end
    m_prev_kv = kv;
    @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0);
    step(1'b0, d, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; key_valid = 1'b1; key_digit = 4'd5; clear = 1'b0; submit = 1'b0;
    ready_for_input = 1'b1; unlock_led = 1'b0; prog_en = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", digit_count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", full); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", match); end
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL reset_key_err: got %b want 0", key_err); end
    n_checks++; if (code_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_code_loaded: got %b want 0", code_loaded); end
    rst = 1'b0;
    model_reset();
    // Key held through reset release must not count.
    repeat (3) step(1'b1, 4'd5, 1'b0, 1'b0);
    n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL held_through_reset: got %0d want 0", digit_count); end
    step(1'b0, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    n_checks++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL repress_after_reset: got %0d want 1", digit_count); end
    step(1'b0, 4'd0, 1'b1, 1'b0);
  endtask

  task automatic test_basic_entry();
    int digits[4] = '{1, 2, 3, 4};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'(digits[i]), 1'b0, 1'b0);
      n_checks++; if (digit_count !== 3'(i + 1)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", digit_count, i + 1); end
      if (i < 3) begin
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL basic_early_full: got %b want 0", full); end
      end
      step(1'b0, 4'd0, 1'b0, 1'b0);
    end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL basic_full: got %b want 1", full); end
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL basic_match: got %b want 1", match); end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_mismatch_submit();
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd5);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL mismatch_full: got %b want 1", full); end
    n_checks++; if (match !== 1'b0) begin n_fail++; $display("FAIL mismatch_match: got %b want 0", match); end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL submit_count: got %0d want 0", digit_count); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL submit_full: got %b want 0", full); end
  endtask

  task automatic test_hold_and_errors();
    int err_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd7, 1'b0, 1'b0);
      if (key_err !== 1'b0) err_seen++;
    end
    n_checks++; if (digit_count !== 3'd1) begin n_fail++; $display("FAIL hold_count: got %0d want 1", digit_count); end
    n_checks++; if (err_seen != 0) begin n_fail++; $display("FAIL hold_key_err: got %0d pulses want 0", err_seen); end
    step(1'b0, 4'd0, 1'b1, 1'b0);
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    step(1'b1, 4'd5, 1'b0, 1'b0);
    n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL overflow_key_err: got %b want 1", key_err); end
    n_checks++; if (digit_count !== 3'd4) begin n_fail++; $display("FAIL overflow_count: got %0d want 4", digit_count); end
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL overflow_buffer: match got %b want 1", match); end
    step(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL overflow_pulse_width: got %b want 0", key_err); end
    step(1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 4'hA, 1'b0, 1'b0);
    n_checks++; if (key_err !== 1'b1) begin n_fail++; $display("FAIL bad_digit_key_err: got %b want 1", key_err); end
    n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL bad_digit_count: got %0d want 0", digit_count); end
    step(1'b0, 4'd0, 1'b0, 1'b0);
    ready_for_input = 1'b0;
    step(1'b1, 4'd3, 1'b0, 1'b0);
    n_checks++; if (key_err !== 1'b1 || digit_count !== 3'd0) begin n_fail++; $display("FAIL not_ready: key_err %b count %0d want 1/0", key_err, digit_count); end
    step(1'b0, 4'd0, 1'b0, 1'b0);
    ready_for_input = 1'b1;
  endtask

  task automatic test_reprogram();
    unlock_led = 1'b1; prog_en = 1'b1;
    press_key(4'd9); press_key(4'd8); press_key(4'd7); press_key(4'd6);
    step(1'b0, 4'd0, 1'b0, 1'b1);
    n_checks++; if (code_loaded !== 1'b1) begin n_fail++; $display("FAIL code_loaded_pulse: got %b want 1", code_loaded); end
    step(1'b0, 4'd0, 1'b0, 1'b0);
    n_checks++; if (code_loaded !== 1'b0) begin n_fail++; $display("FAIL code_loaded_width: got %b want 0", code_loaded); end
    unlock_led = 1'b0; prog_en = 1'b0;
    press_key(4'd9); press_key(4'd8); press_key(4'd7); press_key(4'd6);
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL new_code_match: got %b want 1", match); end
    step(1'b0, 4'd0, 1'b0, 1'b1);
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    n_checks++; if (full !== 1'b1 || match !== 1'b0) begin n_fail++; $display("FAIL old_code_rejected: full %b match %b want 1/0", full, match); end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_clear_and_reset();
    press_key(4'd2); press_key(4'd3);
    step(1'b1, 4'd4, 1'b1, 1'b0);
    n_checks++; if (digit_count !== 3'd0) begin n_fail++; $display("FAIL clear_press_count: got %0d want 0", digit_count); end
    n_checks++; if (key_err !== 1'b0) begin n_fail++; $display("FAIL clear_press_key_err: got %b want 0", key_err); end
    step(1'b0, 4'd0, 1'b0, 1'b0);
    press_key(4'd2); press_key(4'd3);
    rst = 1'b1;
    #1;
    n_checks++; if (digit_count !== 3'd0 || full !== 1'b0 || match !== 1'b0 || key_err !== 1'b0 || code_loaded !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: count %0d full %b match %b key_err %b loaded %b want all 0", digit_count, full, match, key_err, code_loaded);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1'b0, 4'd0, 1'b0, 1'b0);
    press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
    n_checks++; if (match !== 1'b1) begin n_fail++; $display("FAIL reset_restores_code: match got %b want 1", match); end
    step(1'b0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic kv, clr, sub;
    logic [3:0] d;
    for (int c = 0; c < 600; c++) begin
      ready_for_input = ($urandom_range(0, 7) != 0);
      unlock_led      = ($urandom_range(0, 1) != 0);
      prog_en         = ($urandom_range(0, 1) != 0);
      kv  = ($urandom_range(0, 1) != 0);
      d   = 4'($urandom_range(0, 11));
      clr = ($urandom_range(0, 29) == 0);
      sub = (q.size() == 4) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 24) == 0);
      step(kv, d, clr, sub);
      n_checks++; if (digit_count !== 3'(q.size())) begin n_fail++; $display("FAIL rand_count cycle %0d: got %0d want %0d", c, digit_count, q.size()); end
      n_checks++; if (full !== (q.size() == 4)) begin n_fail++; $display("FAIL rand_full cycle %0d: got %b want %b", c, full, q.size() == 4); end
      n_checks++; if (match !== (q.size() == 4 && q_value() == m_stored)) begin n_fail++; $display("FAIL rand_match cycle %0d: got %b", c, match); end
      n_checks++; if (key_err !== m_err) begin n_fail++; $display("FAIL rand_key_err cycle %0d: got %b want %b", c, key_err, m_err); end
      n_checks++; if (code_loaded !== m_loaded) begin n_fail++; $display("FAIL rand_code_loaded cycle %0d: got %b want %b", c, code_loaded, m_loaded); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_entry();
    test_mismatch_submit();
    test_hold_and_errors();
    test_reprogram();
    test_clear_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
